// File: rtl/key_search_scheduler.sv
// Scheduler for a parallel RC4 key search: slices the key space across NUM_CORES cores,
// launches them together and latches the first found key. Optional cycle counter: SEARCH_CYCLE_COUNT_EN.
module key_search_scheduler #(
  parameter int                   NUM_CORES  = 4,
  parameter int                   KEY_WIDTH  = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX    = 24'h3FFFFF,
  parameter int                   CLR_CYCLES = 2,
  parameter int                   IDX_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  output logic                           core_reset_n,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_start_value,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_end_value,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_found,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  output logic                           busy,
  output logic                           done,
  output logic                           found,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [IDX_W-1:0]               found_core
`ifdef SEARCH_CYCLE_COUNT_EN
  ,output logic [31:0]                   elapsed_cycles
`endif
);

  localparam int LOG2_N = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 0;
  localparam int CNT_W  = $clog2(CLR_CYCLES + 1);
  localparam logic [KEY_WIDTH:0] SLICE = ({1'b0, KEY_MAX} + 1'b1) >> LOG2_N;

  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, RUN, HALT, DONE} state_t;

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_clr_cnt;
  logic                 r_found;
  logic [KEY_WIDTH-1:0] r_found_key;
  logic [IDX_W-1:0]     r_found_core;
  logic                 w_accept, w_take_hit, w_take_none;
  logic                 w_any_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic [KEY_WIDTH-1:0] w_hit_key;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_slice
      localparam logic [KEY_WIDTH:0] START_V = (KEY_WIDTH+1)'(SLICE * (KEY_WIDTH+1)'(gi));
      localparam logic [KEY_WIDTH:0] END_V   = START_V + SLICE - 1'b1;
      assign core_start_value[gi*KEY_WIDTH +: KEY_WIDTH] = START_V[KEY_WIDTH-1:0];
      assign core_end_value[gi*KEY_WIDTH +: KEY_WIDTH]   = END_V[KEY_WIDTH-1:0];
    end
  endgenerate

  // Scan from the top down so the lowest-index hit is the one left standing.
  always_comb begin
    w_any_hit = 1'b0;
    w_hit_idx = '0;
    w_hit_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_done[i] && core_found[i]) begin
        w_any_hit = 1'b1;
        w_hit_idx = IDX_W'(i);
        w_hit_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    core_reset_n = 1'b0;
    core_start   = '0;
    busy         = 1'b0;
    done         = 1'b0;
    w_accept     = 1'b0;
    w_take_hit   = 1'b0;
    w_take_none  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = CLEAR;
        end
      end
      CLEAR: begin
        if (r_clr_cnt == '0) w_state_next = LAUNCH;
      end
      LAUNCH: begin
        core_reset_n = 1'b1;
        core_start   = '1;
        busy         = 1'b1;
        w_state_next = RUN;
      end
      RUN: begin
        core_reset_n = 1'b1;
        busy         = 1'b1;
        if (w_any_hit) begin
          w_take_hit   = 1'b1;
          w_state_next = HALT;
        end else if (&core_done) begin
          w_take_none  = 1'b1;
          w_state_next = HALT;
        end
      end
      HALT: w_state_next = DONE;
      DONE: begin
        done = 1'b1;
        if (start) begin
          done         = 1'b0;
          w_accept     = 1'b1;
          w_state_next = CLEAR;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Counter is loaded with CLR_CYCLES and launch follows the cycle it reads zero,
  // so cores come out of reset CLR_CYCLES+1 edges after start is taken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_clr_cnt    <= '0;
      r_found      <= 1'b0;
      r_found_key  <= '0;
      r_found_core <= '0;
    end else begin
      if (w_accept) begin
        r_clr_cnt    <= CNT_W'(CLR_CYCLES);
        r_found      <= 1'b0;
        r_found_key  <= '0;
        r_found_core <= '0;
      end else if (r_state == CLEAR && r_clr_cnt != '0) begin
        r_clr_cnt <= r_clr_cnt - 1'b1;
      end
      if (w_take_hit) begin
        r_found      <= 1'b1;
        r_found_key  <= w_hit_key;
        r_found_core <= w_hit_idx;
      end else if (w_take_none) begin
        r_found     <= 1'b0;
        r_found_key <= '0;
      end
    end
  end

  assign found      = r_found;
  assign found_key  = r_found_key;
  assign found_core = r_found_core;

`ifdef SEARCH_CYCLE_COUNT_EN
  logic [31:0] r_elapsed;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_elapsed <= '0;
    end else if (w_state_next == LAUNCH && r_state != LAUNCH) begin
      r_elapsed <= '0;
    end else if (r_state == RUN && r_elapsed != 32'hFFFF_FFFF) begin
      r_elapsed <= r_elapsed + 1'b1;
    end
  end
  assign elapsed_cycles = r_elapsed;
`endif

endmodule
